// File: rtl/mips_run_monitor.sv
// Run controller and monitor for the single-cycle MIPS core: gates the core with a clock
// enable, counts RUN cycles and data-memory writes, and ends a run on program exit (END),
// a PC self-loop (LOOP) or an exhausted cycle budget (TIMEOUT).
module mips_run_monitor #(
    parameter int unsigned ADDR_W      = 32,
    parameter int unsigned DATA_W      = 32,
    parameter int unsigned INST_COUNT  = 15,
    parameter int unsigned MAX_CYCLES  = 1777,
    parameter int unsigned STALL_LIMIT = 4,
    parameter int unsigned CNT_W       = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start_i,
    input  logic [ADDR_W-1:0] inst_addr_i,
    input  logic              mem_write_i,
    input  logic [ADDR_W-1:0] mem_addr_i,
    input  logic [DATA_W-1:0] mem_wdata_i,
    output logic              core_en_o,
    output logic              done_o,
    output logic [1:0]        halt_cause_o,
    output logic [CNT_W-1:0]  cycle_count_o,
    output logic [CNT_W-1:0]  wr_count_o,
    output logic [ADDR_W-1:0] last_waddr_o,
    output logic [DATA_W-1:0] last_wdata_o
);

    localparam int unsigned StallW = $clog2(STALL_LIMIT + 1);

    // First byte address past the loaded program.
    localparam logic [ADDR_W-1:0] EndAddr   = ADDR_W'(4 * INST_COUNT);
    // Count value held before the final budgeted cycle is counted.
    localparam logic [CNT_W-1:0]  LastCycle = CNT_W'(MAX_CYCLES - 1);
    localparam logic [StallW-1:0] StallLast = StallW'(STALL_LIMIT - 1);

    localparam logic [1:0] CauseNone    = 2'd0;
    localparam logic [1:0] CauseEnd     = 2'd1;
    localparam logic [1:0] CauseLoop    = 2'd2;
    localparam logic [1:0] CauseTimeout = 2'd3;

    typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  cycle_q, cycle_d;
    logic [CNT_W-1:0]  wr_q, wr_d;
    logic [ADDR_W-1:0] waddr_q, waddr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [1:0]        cause_q, cause_d;
    logic [ADDR_W-1:0] prev_addr_q, prev_addr_d;
    logic              prev_valid_q, prev_valid_d;
    logic [StallW-1:0] stall_q, stall_d;

    logic pc_repeat, hit_end, hit_loop, hit_timeout;

    // Halt conditions for the RUN cycle currently being counted.
    always_comb begin
        pc_repeat   = prev_valid_q && (inst_addr_i == prev_addr_q);
        hit_end     = (inst_addr_i >= EndAddr);
        hit_loop    = pc_repeat && (stall_q == StallLast);
        hit_timeout = (cycle_q == LastCycle);
    end

    // Next-state: start/restart clears, RUN counts and captures, halts move to DONE.
    always_comb begin
        state_d      = state_q;
        cycle_d      = cycle_q;
        wr_d         = wr_q;
        waddr_d      = waddr_q;
        wdata_d      = wdata_q;
        cause_d      = cause_q;
        prev_addr_d  = prev_addr_q;
        prev_valid_d = prev_valid_q;
        stall_d      = stall_q;
        unique case (state_q)
            StIdle, StDone: begin
                if (start_i) begin
                    state_d      = StRun;
                    cycle_d      = '0;
                    wr_d         = '0;
                    waddr_d      = '0;
                    wdata_d      = '0;
                    cause_d      = CauseNone;
                    prev_addr_d  = '0;
                    prev_valid_d = 1'b0;
                    stall_d      = '0;
                end
            end
            StRun: begin
                cycle_d = (cycle_q == '1) ? cycle_q : cycle_q + CNT_W'(1);
                if (mem_write_i) begin
                    wr_d    = (wr_q == '1) ? wr_q : wr_q + CNT_W'(1);
                    waddr_d = mem_addr_i;
                    wdata_d = mem_wdata_i;
                end
                prev_addr_d  = inst_addr_i;
                prev_valid_d = 1'b1;
                stall_d      = pc_repeat ? stall_q + StallW'(1) : '0;
                if (hit_end) begin
                    cause_d = CauseEnd;
                    state_d = StDone;
                end else if (hit_loop) begin
                    cause_d = CauseLoop;
                    state_d = StDone;
                end else if (hit_timeout) begin
                    cause_d = CauseTimeout;
                    state_d = StDone;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // State and monitor registers; reset drops core_en without waiting for a clock.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= StIdle;
            cycle_q      <= '0;
            wr_q         <= '0;
            waddr_q      <= '0;
            wdata_q      <= '0;
            cause_q      <= CauseNone;
            prev_addr_q  <= '0;
            prev_valid_q <= 1'b0;
            stall_q      <= '0;
        end else begin
            state_q      <= state_d;
            cycle_q      <= cycle_d;
            wr_q         <= wr_d;
            waddr_q      <= waddr_d;
            wdata_q      <= wdata_d;
            cause_q      <= cause_d;
            prev_addr_q  <= prev_addr_d;
            prev_valid_q <= prev_valid_d;
            stall_q      <= stall_d;
        end
    end

    assign core_en_o     = (state_q == StRun);
    assign done_o        = (state_q == StDone);
    assign halt_cause_o  = cause_q;
    assign cycle_count_o = cycle_q;
    assign wr_count_o    = wr_q;
    assign last_waddr_o  = waddr_q;
    assign last_wdata_o  = wdata_q;

endmodule

// File: tb/tb_mips_run_monitor.sv
// Self-checking bench for mips_run_monitor: directed runs with literal expectations plus
// randomized runs, all compared every cycle against a run-level reference model.
module tb_mips_run_monitor;

    localparam int unsigned INST  = 15;
    localparam int unsigned MAXC  = 20;
    localparam int unsigned STALL = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [31:0] inst_addr = '0;
    logic        mem_write = 1'b0;
    logic [31:0] mem_addr = '0;
    logic [31:0] mem_wdata = '0;
    logic        core_en, done;
    logic [1:0]  halt_cause;
    logic [31:0] cycle_count, wr_count, last_waddr, last_wdata;

    int checks = 0;
    int failures = 0;
    int en_cnt = 0;

    mips_run_monitor #(
        .ADDR_W     (32),
        .DATA_W     (32),
        .INST_COUNT (INST),
        .MAX_CYCLES (MAXC),
        .STALL_LIMIT(STALL),
        .CNT_W      (32)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start_i      (start),
        .inst_addr_i  (inst_addr),
        .mem_write_i  (mem_write),
        .mem_addr_i   (mem_addr),
        .mem_wdata_i  (mem_wdata),
        .core_en_o    (core_en),
        .done_o       (done),
        .halt_cause_o (halt_cause),
        .cycle_count_o(cycle_count),
        .wr_count_o   (wr_count),
        .last_waddr_o (last_waddr),
        .last_wdata_o (last_wdata)
    );

    always #5 clk = ~clk;

    // Reference model: run mode (0 idle, 1 run, 2 done), counts and a short PC history.
    int          m_mode = 0;
    logic [31:0] m_cnt = '0, m_wr = '0, m_la = '0, m_ld = '0;
    logic [1:0]  m_cause = '0;
    logic [31:0] m_hist[$];

    task automatic m_clear();
        m_mode = 0; m_cnt = '0; m_wr = '0; m_la = '0; m_ld = '0; m_cause = '0;
        m_hist.delete();
    endtask

    task automatic m_step();
        bit is_end, is_loop, is_to;
        if (m_mode != 1) begin
            if (start) begin
                m_mode = 1; m_cnt = '0; m_wr = '0; m_la = '0; m_ld = '0; m_cause = '0;
                m_hist.delete();
            end
        end else begin
            m_cnt = m_cnt + 1;
            if (mem_write) begin
                m_wr = m_wr + 1; m_la = mem_addr; m_ld = mem_wdata;
            end
            m_hist.push_back(inst_addr);
            if (m_hist.size() > STALL + 1) void'(m_hist.pop_front());
            is_end = (inst_addr >= 4 * INST);
            // Self-loop: the last STALL+1 PCs of this run are all the same address.
            is_loop = (m_hist.size() == STALL + 1);
            foreach (m_hist[i]) if (m_hist[i] != m_hist[0]) is_loop = 1'b0;
            is_to = (m_cnt == MAXC);
            if (is_end)       begin m_cause = 2'd1; m_mode = 2; end
            else if (is_loop) begin m_cause = 2'd2; m_mode = 2; end
            else if (is_to)   begin m_cause = 2'd3; m_mode = 2; end
        end
    endtask

    initial begin
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) m_clear();
            else m_step();
        end
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Per-cycle comparison against the model, away from the active edge.
    initial begin
        forever begin
            @(negedge clk);
            check("core_en", 64'(core_en), 64'(m_mode == 1));
            check("done", 64'(done), 64'(m_mode == 2));
            check("halt_cause", 64'(halt_cause), 64'(m_cause));
            check("cycle_count", 64'(cycle_count), 64'(m_cnt));
            check("wr_count", 64'(wr_count), 64'(m_wr));
            check("last_waddr", 64'(last_waddr), 64'(m_la));
            check("last_wdata", 64'(last_wdata), 64'(m_ld));
        end
    end

    // Present one cycle of inputs; returns just after the following falling edge.
    task automatic cyc(input logic s, input logic [31:0] pc, input logic we,
                       input logic [31:0] a, input logic [31:0] d);
        start = s; inst_addr = pc; mem_write = we; mem_addr = a; mem_wdata = d;
        @(negedge clk);
        #1;
        if (core_en) en_cnt++;
    endtask

    task automatic mid_reset();
        start = 1'b0;
        rst_n = 1'b0;
        #1;
        check("rst core_en", 64'(core_en), 64'd0);
        check("rst done", 64'(done), 64'd0);
        check("rst cycle_count", 64'(cycle_count), 64'd0);
        check("rst wr_count", 64'(wr_count), 64'd0);
        check("rst halt_cause", 64'(halt_cause), 64'd0);
        check("rst last_waddr", 64'(last_waddr), 64'd0);
        rst_n = 1'b1;
    endtask

    task automatic straight_run();
        cyc(1'b1, 32'd0, 1'b0, 32'd0, 32'd0);
        for (int i = 0; i < 16; i++) cyc(1'b0, 32'(4 * i), 1'b0, 32'd0, 32'd0);
    endtask

    initial begin
        logic [31:0] pc;
        repeat (2) @(negedge clk);
        #1;
        rst_n = 1'b1;
        check("reset core_en", 64'(core_en), 64'd0);
        check("reset cycle_count", 64'(cycle_count), 64'd0);
        check("reset halt_cause", 64'(halt_cause), 64'd0);

        // Straight-line program runs off the end after 16 cycles.
        en_cnt = 0;
        straight_run();
        check("end done", 64'(done), 64'd1);
        check("end cause", 64'(halt_cause), 64'd1);
        check("end cycles", 64'(cycle_count), 64'd16);
        check("end en_cycles", 64'(en_cnt), 64'd16);

        // Restart from DONE clears, then PC parks at 8.
        cyc(1'b1, 32'd0, 1'b0, 32'd0, 32'd0);
        check("restart cause", 64'(halt_cause), 64'd0);
        check("restart cycles", 64'(cycle_count), 64'd0);
        check("restart done", 64'(done), 64'd0);
        cyc(1'b0, 32'd0, 1'b0, 32'd0, 32'd0);
        cyc(1'b0, 32'd4, 1'b0, 32'd0, 32'd0);
        for (int i = 0; i < 5; i++) cyc(1'b0, 32'd8, 1'b0, 32'd0, 32'd0);
        check("loop cause", 64'(halt_cause), 64'd2);
        check("loop cycles", 64'(cycle_count), 64'd7);

        // Ping-pong PC never ends or loops: budget expires.
        en_cnt = 0;
        cyc(1'b1, 32'd0, 1'b0, 32'd0, 32'd0);
        for (int i = 0; i < MAXC; i++) cyc(1'b0, 32'((i % 2) * 4), 1'b0, 32'd0, 32'd0);
        check("timeout cause", 64'(halt_cause), 64'd3);
        check("timeout cycles", 64'(cycle_count), 64'd20);
        check("timeout en_cycles", 64'(en_cnt), 64'd20);

        // Writes: one outside RUN (ignored), two inside, halting by END.
        cyc(1'b0, 32'd0, 1'b1, 32'h99, 32'h99);
        cyc(1'b1, 32'd0, 1'b0, 32'd0, 32'd0);
        for (int i = 0; i < 16; i++) begin
            if (i == 1)      cyc(1'b0, 32'(4 * i), 1'b1, 32'h10, 32'hDEAD);
            else if (i == 4) cyc(1'b0, 32'(4 * i), 1'b1, 32'h14, 32'hBEEF);
            else             cyc(1'b0, 32'(4 * i), 1'b0, 32'd0, 32'd0);
        end
        check("wr wr_count", 64'(wr_count), 64'd2);
        check("wr last_waddr", 64'(last_waddr), 64'h14);
        check("wr last_wdata", 64'(last_wdata), 64'hBEEF);
        check("wr cycles", 64'(cycle_count), 64'd16);

        // Reset during the fifth RUN cycle, then a clean run from zero.
        cyc(1'b1, 32'd0, 1'b0, 32'd0, 32'd0);
        for (int i = 0; i < 4; i++) cyc(1'b0, 32'(4 * i), 1'b1, 32'h40, 32'(i));
        mid_reset();
        en_cnt = 0;
        straight_run();
        check("post-rst cycles", 64'(cycle_count), 64'd16);
        check("post-rst en_cycles", 64'(en_cnt), 64'd16);

        // Minimum run: PC already out of range in the first cycle.
        cyc(1'b1, 32'd0, 1'b0, 32'd0, 32'd0);
        cyc(1'b0, 32'd100, 1'b1, 32'h20, 32'h55);
        check("min cycles", 64'(cycle_count), 64'd1);
        check("min cause", 64'(halt_cause), 64'd1);
        check("min wr_count", 64'(wr_count), 64'd1);

        // END and TIMEOUT coincide on the last budgeted cycle: END wins.
        cyc(1'b1, 32'd0, 1'b0, 32'd0, 32'd0);
        for (int i = 0; i < MAXC - 1; i++) cyc(1'b0, 32'((i % 2) * 4), 1'b0, 32'd0, 32'd0);
        cyc(1'b0, 32'd200, 1'b0, 32'd0, 32'd0);
        check("end+to cause", 64'(halt_cause), 64'd1);
        check("end+to cycles", 64'(cycle_count), 64'd20);

        // Randomized runs, checked every cycle by the compare process.
        pc = '0;
        for (int n = 0; n < 1500; n++) begin
            logic s;
            int   r;
            s = ($urandom_range(0, 7) == 0);
            r = $urandom_range(0, 9);
            if (r < 4)       pc = pc;
            else if (r < 8)  pc = pc + 32'd4;
            else if (r == 8) pc = 32'($urandom_range(0, 16)) * 32'd4;
            else             pc = $urandom;
            if (s) pc = '0;
            if ($urandom_range(0, 199) == 0) mid_reset();
            cyc(s, pc, ($urandom_range(0, 2) == 0), $urandom, $urandom);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
